// File: rtl/rtc_bus_cycle.sv
// Bus-cycle engine for the RTC multiplexed AD bus: address, gap, data, recovery, done.
// Optional RTC_RD_SYNC_EN: two-flop ad_in synchronizer, read data phase two clocks longer.
module rtc_bus_cycle #(
    parameter int T_ADDR = 4,
    parameter int T_GAP  = 2,
    parameter int T_DATA = 6,
    parameter int T_REC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP, S_DATA, S_REC, S_DONE
    } state_t;

    localparam logic [7:0] LD_ADDR  = 8'(T_ADDR - 1);
    localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);
    localparam logic [7:0] LD_WDATA = 8'(T_DATA - 1);
    localparam logic [7:0] LD_REC   = 8'(T_REC - 1);

    logic [7:0] cap_src;

`ifdef RTC_RD_SYNC_EN
    localparam logic [7:0] LD_RDATA = 8'(T_DATA + 1);
    logic [7:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= ad_in;
            sync2_q <= sync1_q;
        end
    end

    assign cap_src = sync2_q;
`else
    localparam logic [7:0] LD_RDATA = 8'(T_DATA - 1);
    assign cap_src = ad_in;
`endif

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic       a_d_q, a_d_d, cs_q, cs_d;
    logic       rd_q, rd_d, wr_q, wr_d;
    logic       ad_oe_q, ad_oe_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       cnt_zero;

    assign cnt_zero = (cnt_q == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            rw_q     <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_d_q    <= 1'b1;
            cs_q     <= 1'b1;
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            a_d_q    <= a_d_d;
            cs_q     <= cs_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR;
                    cnt_d   = LD_ADDR;
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            S_ADDR: begin
                if (cnt_zero) begin
                    state_d = S_GAP;
                    cnt_d   = LD_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = S_DATA;
                    cnt_d   = rw_q ? LD_RDATA : LD_WDATA;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    state_d = S_REC;
                    cnt_d   = LD_REC;
                    // rd is still low on this edge, so the bus value is valid
                    if (rw_q) rdata_d = cap_src;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_REC: begin
                if (cnt_zero) begin
                    state_d = S_DONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes from a flop
    always_comb begin
        busy_d   = 1'b1;
        done_d   = 1'b0;
        a_d_d    = 1'b1;
        cs_d     = 1'b1;
        rd_d     = 1'b1;
        wr_d     = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;
        unique case (state_d)
            S_IDLE: busy_d = 1'b0;
            S_ADDR: begin
                a_d_d    = 1'b0;
                cs_d     = 1'b0;
                wr_d     = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            S_GAP: begin
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            S_DATA: begin
                cs_d = 1'b0;
                if (rw_d) begin
                    rd_d = 1'b0;
                end else begin
                    wr_d     = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
            end
            S_REC:   ;
            S_DONE:  done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign a_d    = a_d_q;
    assign cs     = cs_q;
    assign rd     = rd_q;
    assign wr     = wr_q;
    assign ad_oe  = ad_oe_q;
    assign ad_out = ad_out_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Testbench for rtc_bus_cycle: directed and random transactions checked
// cycle by cycle against a phase-table reference model.
module tb_rtc_bus_cycle;

    localparam int TA = 4;
    localparam int TG = 2;
    localparam int TD = 6;
    localparam int TR = 4;
`ifdef RTC_RD_SYNC_EN
    localparam int RX = 2;
`else
    localparam int RX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] ad_in = 8'h00;
    logic       busy, done, a_d, cs, rd, wr, ad_oe;
    logic [7:0] rdata, ad_out;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_rdata = 8'h00;

    always #5 clk = ~clk;

    rtc_bus_cycle dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    task automatic check(input string tag, input logic [22:0] obs,
                         input logic [22:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Expected pins in cycle k after accept (k = 0: idle)
    function automatic logic [22:0] model(input int k, input logic r,
                                          input logic [7:0] a,
                                          input logic [7:0] w,
                                          input logic [7:0] rold,
                                          input logic [7:0] rnew);
        int         td;
        logic       b, dn, ad, c, rl, wl, oe;
        logic [7:0] o, rq;
        td = r ? TD + RX : TD;
        b = 1'b1; dn = 1'b0; ad = 1'b1; c = 1'b1;
        rl = 1'b1; wl = 1'b1; oe = 1'b0; o = 8'h00; rq = rold;
        if (k <= 0) begin
            b = 1'b0;
        end else if (k <= TA) begin
            ad = 1'b0; c = 1'b0; wl = 1'b0; oe = 1'b1; o = a;
        end else if (k <= TA + TG) begin
            oe = 1'b1; o = a;
        end else if (k <= TA + TG + td) begin
            c = 1'b0;
            if (r) rl = 1'b0;
            else begin wl = 1'b0; oe = 1'b1; o = w; end
        end else begin
            rq = rnew;
            if (k == TA + TG + td + TR + 1) dn = 1'b1;
        end
        return {b, dn, ad, c, rl, wl, oe, o, rq};
    endfunction

    function automatic logic [22:0] obs(input logic oe_exp);
        return {busy, done, a_d, cs, rd, wr, ad_oe,
                oe_exp ? ad_out : 8'h00, rdata};
    endfunction

    task automatic idle_check(input string tag);
        logic [22:0] e;
        e = model(0, 1'b0, 8'h00, 8'h00, m_rdata, m_rdata);
        check(tag, obs(e[16]), e);
    endtask

    // Entered and left at a negedge with the DUT idle
    task automatic run_txn(input logic r, input logic [7:0] a,
                           input logic [7:0] w, input logic [7:0] rdv,
                           input bit inject, input int abort_k);
        int          len;
        logic [7:0]  nw;
        logic [22:0] e;
        len = TA + TG + (r ? TD + RX : TD) + TR + 1;
        nw = r ? rdv : m_rdata;
        start = 1'b1; rw = r; addr = a; wdata = w;
        @(negedge clk);
        for (int k = 1; k <= len; k++) begin
            e = model(k, r, a, w, m_rdata, nw);
            check($sformatf("txn r%0d a%h k%0d", r, a, k), obs(e[16]), e);
            if (k == abort_k) begin
                rst = 1'b0; start = 1'b0;
                @(negedge clk);
                m_rdata = 8'h00;
                idle_check("abort_reset");
                rst = 1'b1;
                @(negedge clk);
                idle_check("abort_nodone");
                return;
            end
            start = inject ? 1'($urandom) : 1'b0;
            rw    = 1'($urandom);
            addr  = 8'($urandom);
            wdata = 8'($urandom);
            ad_in = !rd ? rdv : 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        m_rdata = nw;
        idle_check($sformatf("post r%0d a%h", r, a));
    endtask

    initial begin
        rst = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        idle_check("reset_hold");
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        idle_check("reset_release");

        run_txn(1'b0, 8'h21, 8'h45, 8'h00, 1'b0, 0);
        run_txn(1'b1, 8'h22, 8'h00, 8'h37, 1'b0, 0);
        run_txn(1'b1, 8'h23, 8'h00, 8'h9c, 1'b0, 0);
        run_txn(1'b0, 8'h10, 8'h5a, 8'h00, 1'b0, 0);
        run_txn(1'b0, 8'h31, 8'h7e, 8'h00, 1'b1, 0);
        run_txn(1'b1, 8'h32, 8'h00, 8'hc3, 1'b1, 0);
        run_txn(1'b0, 8'h55, 8'haa, 8'h00, 1'b0, TA + TG + 3);
        run_txn(1'b0, 8'h56, 8'h0f, 8'h00, 1'b0, 0);
        run_txn(1'b1, 8'h57, 8'h00, 8'he1, 1'b0, 0);

        repeat (20) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                ad_in = 8'($urandom);
                @(negedge clk);
                idle_check("gap");
            end
            run_txn(1'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 1'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
